// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller.
package seg_pkg;

    // Width of one digit code; codes are passed through untouched.
    localparam int CODE_W = 3;

    // Code sent to the decoder whenever nothing should be displayed.
    localparam logic [CODE_W-1:0] SEG_BLANK_CODE = 3'd7;

    // Scan FSM states: BLANK keeps every digit off, SHOW lights one digit.
    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } seg_state_e;

    // Larger of two integers, used to size the slot timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bundle of the value-side inputs and display-side outputs of the scanner.
// No handshake: load is a one-cycle strobe, digit_en is sampled live, and all
// display outputs are registered inside the controller.
interface seg_scan_ctrl_if import seg_pkg::*; #(
    parameter int NUM_DIGITS = 4
);

    logic                           load;
    logic [CODE_W*NUM_DIGITS-1:0]   digits_in;
    logic [NUM_DIGITS-1:0]          digit_en;
    logic [CODE_W-1:0]              bcd;
    logic [NUM_DIGITS-1:0]          anode_n;
    logic                           frame_done;
    logic                           pending;

    // Producer side: supplies digit data and enables, observes the display.
    modport master (
        output load, digits_in, digit_en,
        input  bcd, anode_n, frame_done, pending
    );

    // Scan controller side.
    modport slave (
        input  load, digits_in, digit_en,
        output bcd, anode_n, frame_done, pending
    );

endinterface

// File: rtl/seg_slot_timer.sv
// Loadable down-counter that times each BLANK/SHOW slot; zero marks the
// last cycle of the current slot.
module seg_slot_timer #(
    parameter int W       = 4,
    parameter int RST_VAL = 0
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Reload on request, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= W'(RST_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin seven-segment scanner with blanking gaps between digits and a
// double-buffered digit store that commits at frame end.
module seg_scan_ctrl import seg_pkg::*; #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic             clock,
    input  logic             resetn,
    seg_scan_ctrl_if.slave   bus,
    output seg_state_e       dbg_state
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(max_int(PRESCALE, BLANK_CYCLES));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    seg_state_e                           state_q, state_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [CODE_W-1:0]                    bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]                anode_n_q, anode_n_d;
    logic                                 frame_done_q, frame_done_d;
    logic                                 pending_q, pending_d;
    logic [NUM_DIGITS-1:0][CODE_W-1:0]    active_q, active_d;
    logic [NUM_DIGITS-1:0][CODE_W-1:0]    shadow_q, shadow_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             enter_blank;
    logic             commit;

    seg_slot_timer #(
        .W       (CNT_W),
        .RST_VAL (BLANK_CYCLES - 1)
    ) u_timer (
        .clock    (clock),
        .resetn   (resetn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next-state, slot index, buffer commit and registered display outputs.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        bcd_d        = bcd_q;
        anode_n_d    = anode_n_q;
        frame_done_d = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = CNT_W'(BLANK_CYCLES - 1);
        enter_blank  = 1'b0;
        commit       = 1'b0;

        case (state_q)
            ST_BLANK: begin
                anode_n_d = '1;
                if (tmr_zero) begin
                    state_d   = ST_SHOW;
                    tmr_load  = 1'b1;
                    tmr_val   = CNT_W'(PRESCALE - 1);
                    anode_n_d = bus.digit_en[idx_q] ? ~(NUM_DIGITS'(1) << idx_q) : '1;
                end
            end
            ST_SHOW: begin
                // A dropped enable releases the anode; a rising one waits
                // for the digit's next slot.
                anode_n_d = bus.digit_en[idx_q] ? anode_n_q : '1;
                if (tmr_zero) begin
                    state_d     = ST_BLANK;
                    tmr_load    = 1'b1;
                    anode_n_d   = '1;
                    enter_blank = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d        = '0;
                        commit       = 1'b1;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_BLANK;
            end
        endcase

        // A load on the commit cycle flows straight through to active.
        shadow_d  = bus.load ? bus.digits_in : shadow_q;
        active_d  = commit ? shadow_d : active_q;
        pending_d = commit ? 1'b0 : (bus.load ? 1'b1 : pending_q);

        // The code is chosen once per slot so it is stable while lit.
        if (enter_blank) begin
            bcd_d = bus.digit_en[idx_d] ? active_d[idx_d] : SEG_BLANK_CODE;
        end
    end

    // State, index, buffers and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_BLANK;
            idx_q        <= '0;
            bcd_q        <= SEG_BLANK_CODE;
            anode_n_q    <= '1;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
            active_q     <= {NUM_DIGITS{SEG_BLANK_CODE}};
            shadow_q     <= {NUM_DIGITS{SEG_BLANK_CODE}};
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            bcd_q        <= bcd_d;
            anode_n_q    <= anode_n_d;
            frame_done_q <= frame_done_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
        end
    end

    assign bus.bcd        = bcd_q;
    assign bus.anode_n    = anode_n_q;
    assign bus.frame_done = frame_done_q;
    assign bus.pending    = pending_q;
    assign dbg_state      = state_q;

endmodule
